// File: rtl/sap1_pkg.sv
// Shared types and helpers for the SAP-1 bus selector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sap1_pkg;

  // Selector FSM: RUN passes data, BREAK holds the bus idle during a switch.
  typedef enum logic {
    RUN   = 1'b0,
    BREAK = 1'b1
  } state_e;

  // Value driven onto the bus while strobed off or switching.
  localparam int OUT_IDLE = 0;

  // Ceiling log2 with a floor of 1 so single-entry ranges still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_guard_timer.sv
// Up-counter from 0 to MAX-1 with clear, enable and terminal flag.
// Latency: count updates on the edge after en; tc is combinational from the count.
// Backpressure: none; en simply holds the count when low.
module mux_guard_timer
  import sap1_pkg::*;
#(
  parameter int MAX = 1,
  parameter int CW  = clog2(MAX)
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == CW'(MAX - 1));

  // Next count: clear wins, otherwise advance and wrap at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_sel_reg.sv
// Registered N-way bus selector with strobe, break-before-make switching and auto-scan.
// Latency: 1 cycle din->out; a channel switch takes GUARD+1 cycles to new data.
// Backpressure: none; requests during a switch are dropped, illegal ones pulse err.
module mux_sel_reg
  import sap1_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int GUARD    = 1,
  parameter int DWELL    = 8,
  parameter int SW       = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      strobe_n,
  input  logic                      scan_en,
  input  logic                      sel_req,
  input  logic [SW-1:0]             sel_in,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [WIDTH-1:0]          out,
  output logic [SW-1:0]             cur_sel,
  output logic                      busy,
  output logic                      err
);

  state_e            state_q,   state_d;
  logic [SW-1:0]     cur_sel_q, cur_sel_d;
  logic [SW-1:0]     pend_q,    pend_d;
  logic [WIDTH-1:0]  out_q,     out_d;
  logic              busy_q,    busy_d;
  logic              err_q,     err_d;

  logic              req_legal;
  logic              req_noop;
  logic              req_switch;
  logic              self_req;
  logic              guard_tc;
  logic              dwell_tc;
  logic              dwell_clr;
  logic              dwell_en;
  logic [SW-1:0]     next_sel;
  logic [WIDTH-1:0]  data_d;

  // Extract channel idx from the packed input bus.
  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                            input logic [SW-1:0] idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(idx) == k) begin
        r = bus[k*WIDTH +: WIDTH];
      end
    end
    return r;
  endfunction

  // Request decode and scan sequencing terms.
  always_comb begin
    req_legal  = sel_req && (int'(sel_in) < CHANNELS);
    req_noop   = req_legal && (sel_in == cur_sel_q);
    req_switch = req_legal && !req_noop;
    self_req   = scan_en && dwell_tc && !sel_req;
    next_sel   = (int'(cur_sel_q) == CHANNELS - 1) ? '0 : cur_sel_q + SW'(1);
    // Dwell runs only in RUN with scan on; any accepted request restarts it,
    // a rejected request just freezes it for that cycle.
    dwell_en   = (state_q == RUN) && scan_en && !sel_req;
    dwell_clr  = (state_q != RUN) || !scan_en || req_legal || self_req;
  end

  // Guard interval: counts only while the bus is held idle.
  mux_guard_timer #(.MAX(GUARD)) u_guard (
    .clk   (clk),
    .clr_n (clr_n),
    .clr   (state_q != BREAK),
    .en    (state_q == BREAK),
    .tc    (guard_tc)
  );

  // Dwell interval: time spent on a channel before the scan advances.
  mux_guard_timer #(.MAX(DWELL)) u_dwell (
    .clk   (clk),
    .clr_n (clr_n),
    .clr   (dwell_clr),
    .en    (dwell_en),
    .tc    (dwell_tc)
  );

  // Next-state for FSM, selection and output data.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    pend_d    = pend_q;
    err_d     = 1'b0;
    data_d    = pick(din, cur_sel_q);
    case (state_q)
      RUN: begin
        if (sel_req && !req_legal) begin
          err_d = 1'b1;
        end else if (req_switch) begin
          pend_d  = sel_in;
          state_d = BREAK;
          data_d  = WIDTH'(OUT_IDLE);
        end else if (self_req) begin
          pend_d  = next_sel;
          state_d = BREAK;
          data_d  = WIDTH'(OUT_IDLE);
        end
      end
      BREAK: begin
        data_d = WIDTH'(OUT_IDLE);
        if (guard_tc) begin
          cur_sel_d = pend_q;
          state_d   = RUN;
          data_d    = pick(din, pend_q);
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    busy_d = (state_d == BREAK);
    out_d  = strobe_n ? WIDTH'(OUT_IDLE) : data_d;
  end

  // FSM and registered outputs; reset drops any pending selection.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= RUN;
      cur_sel_q <= '0;
      pend_q    <= '0;
      out_q     <= WIDTH'(OUT_IDLE);
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign out     = out_q;
  assign cur_sel = cur_sel_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mux_sel_reg.sv
module tb_mux_sel_reg;

  logic        clk = 1'b0;
  logic        clr_n;
  always #5 clk = ~clk;

  // dut1: 3 channels x 4 bits, GUARD=1, DWELL=2
  logic        strobe_n, scan_en, sel_req;
  logic [1:0]  sel_in;
  logic [11:0] din;
  logic [3:0]  out;
  logic [1:0]  cur_sel;
  logic        busy, err;

  // dut2: 4 channels x 8 bits, GUARD=3, DWELL=3
  logic        s2_strobe_n, s2_scan_en, s2_sel_req;
  logic [1:0]  s2_sel_in;
  logic [31:0] s2_din;
  logic [7:0]  s2_out;
  logic [1:0]  s2_cur_sel;
  logic        s2_busy, s2_err;

  int n_checks = 0;
  int n_fail   = 0;

  mux_sel_reg #(.WIDTH(4), .CHANNELS(3), .GUARD(1), .DWELL(2)) dut (
    .clk(clk), .clr_n(clr_n), .strobe_n(strobe_n), .scan_en(scan_en),
    .sel_req(sel_req), .sel_in(sel_in), .din(din), .out(out),
    .cur_sel(cur_sel), .busy(busy), .err(err)
  );

  mux_sel_reg #(.WIDTH(8), .CHANNELS(4), .GUARD(3), .DWELL(3)) dut2 (
    .clk(clk), .clr_n(clr_n), .strobe_n(s2_strobe_n), .scan_en(s2_scan_en),
    .sel_req(s2_sel_req), .sel_in(s2_sel_in), .din(s2_din), .out(s2_out),
    .cur_sel(s2_cur_sel), .busy(s2_busy), .err(s2_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; strobe_n = 1'b0; scan_en = 1'b0; sel_req = 1'b0; sel_in = 2'd0;
    din = {4'h3, 4'h5, 4'hA};
    s2_strobe_n = 1'b0; s2_scan_en = 1'b0; s2_sel_req = 1'b0; s2_sel_in = 2'd0;
    s2_din = {8'h44, 8'h33, 8'h22, 8'h11};
    tick(); tick();
    n_checks++; if (out !== 4'h0) begin n_fail++; $display("FAIL reset_out: got %h want %h", out, 4'h0); end
    n_checks++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL reset_cur_sel: got %0d want 0", cur_sel); end
    n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got busy=%b err=%b want 0 0", busy, err); end
    clr_n = 1'b1;
    tick();
    n_checks++; if (out !== 4'hA) begin n_fail++; $display("FAIL release_out: got %h want %h", out, 4'hA); end
    n_checks++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL release_cur_sel: got %0d want 0", cur_sel); end
    n_checks++; if (s2_out !== 8'h11) begin n_fail++; $display("FAIL release_out2: got %h want %h", s2_out, 8'h11); end
  endtask

  task automatic test_switch();
    sel_in = 2'd1; sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    n_checks++; if (out !== 4'h0 || busy !== 1'b1) begin n_fail++; $display("FAIL switch_break: got out=%h busy=%b want 0 1", out, busy); end
    n_checks++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL switch_break_sel: got %0d want 0", cur_sel); end
    tick();
    n_checks++; if (out !== 4'h5 || busy !== 1'b0) begin n_fail++; $display("FAIL switch_done: got out=%h busy=%b want 5 0", out, busy); end
    n_checks++; if (cur_sel !== 2'd1) begin n_fail++; $display("FAIL switch_done_sel: got %0d want 1", cur_sel); end
    // same channel again: no break
    sel_in = 2'd1; sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    n_checks++; if (out !== 4'h5 || busy !== 1'b0) begin n_fail++; $display("FAIL switch_noop: got out=%h busy=%b want 5 0", out, busy); end
  endtask

  task automatic test_illegal();
    sel_in = 2'd3; sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b want 1", err); end
    n_checks++; if (cur_sel !== 2'd1 || out !== 4'h5 || busy !== 1'b0) begin n_fail++; $display("FAIL illegal_state: got sel=%0d out=%h busy=%b want 1 5 0", cur_sel, out, busy); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pulse: got %b want 0", err); end
    n_checks++; if (out !== 4'h5) begin n_fail++; $display("FAIL illegal_out_after: got %h want 5", out); end
  endtask

  task automatic test_scan();
    logic [3:0] exp_scan [10];
    exp_scan = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h3, 4'h3, 4'h0, 4'h1};
    din = {4'h3, 4'h2, 4'h1};
    sel_in = 2'd0; sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    tick();
    scan_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) tick();
      n_checks++;
      if (out !== exp_scan[i]) begin
        n_fail++; $display("FAIL scan_seq[%0d]: got %h want %h", i, out, exp_scan[i]);
      end
    end
  endtask

  task automatic test_strobe();
    // scan continues from channel 0 with dwell at 0
    strobe_n = 1'b1;
    tick();
    n_checks++; if (out !== 4'h0) begin n_fail++; $display("FAIL strobe_e1: got %h want 0", out); end
    tick();
    n_checks++; if (out !== 4'h0 || busy !== 1'b1) begin n_fail++; $display("FAIL strobe_e2: got out=%h busy=%b want 0 1", out, busy); end
    tick();
    n_checks++; if (out !== 4'h0 || cur_sel !== 2'd1) begin n_fail++; $display("FAIL strobe_e3: got out=%h sel=%0d want 0 1", out, cur_sel); end
    strobe_n = 1'b0;
    tick();
    n_checks++; if (out !== 4'h2 || cur_sel !== 2'd1) begin n_fail++; $display("FAIL strobe_release: got out=%h sel=%0d want 2 1", out, cur_sel); end
    scan_en = 1'b0;
    tick();
    n_checks++; if (out !== 4'h2 || busy !== 1'b0) begin n_fail++; $display("FAIL scan_off_hold: got out=%h busy=%b want 2 0", out, busy); end
  endtask

  task automatic test_guard_long();
    s2_sel_in = 2'd2; s2_sel_req = 1'b1;
    tick();
    s2_sel_req = 1'b0;
    n_checks++; if (s2_out !== 8'h00 || s2_busy !== 1'b1) begin n_fail++; $display("FAIL guard3_e0: got out=%h busy=%b want 00 1", s2_out, s2_busy); end
    // request during break must be ignored
    s2_sel_in = 2'd3; s2_sel_req = 1'b1;
    tick();
    s2_sel_req = 1'b0;
    n_checks++; if (s2_out !== 8'h00 || s2_busy !== 1'b1 || s2_err !== 1'b0) begin n_fail++; $display("FAIL guard3_e1: got out=%h busy=%b err=%b want 00 1 0", s2_out, s2_busy, s2_err); end
    tick();
    n_checks++; if (s2_out !== 8'h00 || s2_busy !== 1'b1 || s2_cur_sel !== 2'd0) begin n_fail++; $display("FAIL guard3_e2: got out=%h busy=%b sel=%0d want 00 1 0", s2_out, s2_busy, s2_cur_sel); end
    tick();
    n_checks++; if (s2_out !== 8'h33 || s2_busy !== 1'b0 || s2_cur_sel !== 2'd2) begin n_fail++; $display("FAIL guard3_done: got out=%h busy=%b sel=%0d want 33 0 2", s2_out, s2_busy, s2_cur_sel); end
  endtask

  task automatic test_reset_mid_break();
    sel_in = 2'd2; sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    tick();
    n_checks++; if (cur_sel !== 2'd2 || out !== 4'h3) begin n_fail++; $display("FAIL pre_reset_sel: got sel=%0d out=%h want 2 3", cur_sel, out); end
    sel_in = 2'd1; sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
    #1 clr_n = 1'b0;
    #1;
    n_checks++; if (out !== 4'h0 || busy !== 1'b0 || cur_sel !== 2'd0) begin n_fail++; $display("FAIL async_reset: got out=%h busy=%b sel=%0d want 0 0 0", out, busy, cur_sel); end
    #1 clr_n = 1'b1;
    tick();
    n_checks++; if (out !== 4'h1 || cur_sel !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL after_reset: got out=%h sel=%0d busy=%b want 1 0 0", out, cur_sel, busy); end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_illegal();
    test_guard_long();
    test_scan();
    test_strobe();
    test_reset_mid_break();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
